// File: rtl/mult_arb.sv
// Round-robin arbiter/sequencer sharing one multi-cycle mult unit among NREQ requesters.
// Optional watchdog abort in WAIT is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arb #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic [NREQ*W-1:0] op_c,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [NREQ-1:0] err,
  output logic [W-1:0]    res,
  output logic            res_flag,
  output logic            mul_activate,
  output logic            mul_reset,
  output logic            mul_a,
  output logic [W-1:0]    mul_b,
  output logic [W-1:0]    mul_c,
  input  logic [W-1:0]    mul_div,
  input  logic            mul_mod,
  input  logic            mul_endop
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("mult_arb: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
`ifdef MULT_ARB_TIMEOUT_EN
    S_RESP  = 3'd3,
    S_ABORT = 3'd4
`else
    S_RESP  = 3'd3
`endif
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   owner_r;
  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] done_r;
  logic [W-1:0]    res_r;
  logic            res_flag_r;
  logic            mul_act_r;
  logic            mul_a_r;
  logic [W-1:0]    mul_b_r;
  logic [W-1:0]    mul_c_r;

  logic [PW-1:0]   pick_s;
  logic [PW-1:0]   sel_s;
  logic            any_s;
  logic [PW-1:0]   next_ptr_s;

  // Requester index k positions after base, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rot_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    s = (s >= NREQ) ? (s - NREQ) : s;
    return PW'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan from the far end so the slot nearest the pointer wins.
  always_comb begin
    pick_s = '0;
    sel_s  = '0;
    any_s  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel_s  = rot_idx(ptr_r, k);
      pick_s = req[sel_s] ? sel_s : pick_s;
      any_s  = any_s | req[sel_s];
    end
  end

  // Priority moves just past the owner that finished.
  always_comb begin
    if (owner_r == PW'(NREQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = owner_r + PW'(1);
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0]   cnt_r;
  logic            abort_r;
  logic [NREQ-1:0] err_r;
`endif

  // Sequencer FSM: IDLE -> ISSUE -> WAIT -> RESP (or ABORT) -> IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      ptr_r      <= '0;
      owner_r    <= '0;
      gnt_r      <= '0;
      done_r     <= '0;
      res_r      <= '0;
      res_flag_r <= 1'b0;
      mul_act_r  <= 1'b0;
      mul_a_r    <= 1'b0;
      mul_b_r    <= '0;
      mul_c_r    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_r      <= '0;
      abort_r    <= 1'b0;
      err_r      <= '0;
`endif
    end else begin
      done_r    <= '0;
      mul_act_r <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      abort_r   <= 1'b0;
      err_r     <= '0;
`endif
      case (state_r)
        S_IDLE: begin
          if (any_s) begin
            owner_r   <= pick_s;
            gnt_r     <= onehot(pick_s);
            mul_a_r   <= op_a[pick_s];
            mul_b_r   <= op_b[int'(pick_s)*W +: W];
            mul_c_r   <= op_c[int'(pick_s)*W +: W];
            mul_act_r <= 1'b1;
            state_r   <= S_ISSUE;
          end else begin
            state_r   <= S_IDLE;
          end
        end
        S_ISSUE: begin
`ifdef MULT_ARB_TIMEOUT_EN
          cnt_r   <= '0;
`endif
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          // endop in the expiring cycle still completes normally
          if (mul_endop) begin
            res_r      <= mul_div;
            res_flag_r <= mul_mod;
            done_r     <= gnt_r;
            state_r    <= S_RESP;
`ifdef MULT_ARB_TIMEOUT_EN
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            abort_r    <= 1'b1;
            err_r      <= gnt_r;
            state_r    <= S_ABORT;
          end else begin
            cnt_r      <= cnt_r + CW'(1);
`else
          end else begin
`endif
            state_r    <= S_WAIT;
          end
        end
        S_RESP: begin
          gnt_r   <= '0;
          ptr_r   <= next_ptr_s;
          state_r <= S_IDLE;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        S_ABORT: begin
          gnt_r   <= '0;
          ptr_r   <= next_ptr_s;
          state_r <= S_IDLE;
        end
`endif
        default: begin
          gnt_r   <= '0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt          = gnt_r;
  assign done         = done_r;
  assign res          = res_r;
  assign res_flag     = res_flag_r;
  assign mul_activate = mul_act_r;
  assign mul_a        = mul_a_r;
  assign mul_b        = mul_b_r;
  assign mul_c        = mul_c_r;
`ifdef MULT_ARB_TIMEOUT_EN
  assign err          = err_r;
  assign mul_reset    = reset | abort_r;
`else
  assign err          = '0;
  assign mul_reset    = reset;
`endif

endmodule

// File: tb/tb_mult_arb.sv
// Scoreboard bench for mult_arb: a behavioural mult responds to mul_activate, expected
// grants and results are queued by the stimulus and popped by an independent monitor.
module tb_mult_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TMO  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ*W-1:0] op_c;
  logic [NREQ-1:0]   gnt, done, err;
  logic [W-1:0]      res;
  logic              res_flag;
  logic              mul_activate, mul_reset, mul_a;
  logic [W-1:0]      mul_b, mul_c;
  logic [W-1:0]      mul_div;
  logic              mul_mod;
  logic              mul_endop;

  mult_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .gnt(gnt), .done(done), .err(err), .res(res), .res_flag(res_flag),
    .mul_activate(mul_activate), .mul_reset(mul_reset), .mul_a(mul_a),
    .mul_b(mul_b), .mul_c(mul_c), .mul_div(mul_div), .mul_mod(mul_mod),
    .mul_endop(mul_endop)
  );

  always #5 clk = ~clk;

  // Per-requester operands and hand-computed mult results:
  // div = a ? b*c : b+c (truncated to W), mod = (b > c)
  logic         tb_a [NREQ] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [W-1:0] tb_b [NREQ] = '{8'd2, 8'd200, 8'd16, 8'd9};
  logic [W-1:0] tb_c [NREQ] = '{8'd5, 8'd100, 8'd17, 8'd3};
  logic [W-1:0] x_res [NREQ] = '{8'd10, 8'd44, 8'd16, 8'd12};
  logic         x_flag[NREQ] = '{1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct {
    logic [NREQ-1:0] vec;
    logic [W-1:0]    r;
    logic            f;
  } exp_t;

  exp_t done_q[$];
  int   gnt_q[$];

  int n_chk = 0;
  int n_err = 0;

  int lat    = 1;
  bit hang   = 1'b0;
  bit glitch = 1'b0;
  bit err_exp = 1'b0;
  logic [NREQ-1:0] err_vec = '0;
  int err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic push(input int i);
    exp_t e;
    e.vec = '0;
    e.vec[i] = 1'b1;
    e.r = x_res[i];
    e.f = x_flag[i];
    gnt_q.push_back(i);
    done_q.push_back(e);
  endtask

  // Behavioural mult: answers `lat` cycles after activate unless hung.
  initial begin
    mul_endop = 1'b0;
    mul_div   = '0;
    mul_mod   = 1'b0;
    forever begin
      @(negedge clk);
      if (mul_activate && !hang) begin
        mul_endop = glitch;
        mul_div   = 8'hEE;
        mul_mod   = 1'b1;
        @(negedge clk);
        mul_endop = 1'b0;
        repeat (lat - 1) @(negedge clk);
        mul_endop = 1'b1;
        mul_div   = mul_a ? mul_b * mul_c : mul_b + mul_c;
        mul_mod   = (mul_b > mul_c);
        @(negedge clk);
        mul_endop = 1'b0;
      end
    end
  end

  // Monitor: pops expected grants on activate and expected results on done.
  initial begin : monitor
    logic prev_act;
    int   gi;
    exp_t e;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mul_activate) begin
          chk("activate_one_cycle", 32'(prev_act), 32'd0);
          if (gnt_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_grant: got gnt=%b, required no grant", gnt);
          end else begin
            gi = gnt_q.pop_front();
            chk("gnt", 32'(gnt), 32'(1 << gi));
            chk("mul_a", 32'(mul_a), 32'(tb_a[gi]));
            chk("mul_b", 32'(mul_b), 32'(tb_b[gi]));
            chk("mul_c", 32'(mul_c), 32'(tb_c[gi]));
          end
        end
        if (done != '0) begin
          if (done_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_done: got done=%b, required none", done);
          end else begin
            e = done_q.pop_front();
            chk("done", 32'(done), 32'(e.vec));
            chk("res", 32'(res), 32'(e.r));
            chk("res_flag", 32'(res_flag), 32'(e.f));
            chk("gnt_in_resp", 32'(gnt), 32'(e.vec));
          end
        end
        if (err != '0) begin
          if (err_exp) begin
            chk("err", 32'(err), 32'(err_vec));
            chk("mul_reset_abort", 32'(mul_reset), 32'd1);
            err_seen++;
          end else begin
            n_chk++; n_err++;
            $display("FAIL unexpected_err: got err=%b, required 0", err);
          end
        end
      end
      prev_act = mul_activate;
    end
  end

  task automatic wait_dones(input int n, input bit drop_each, input bit clear_last, input string name);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        seen++;
        if (drop_each) req = req & ~done;
        if (clear_last && seen == n) req = '0;
      end
    end
    if (seen < n) begin
      n_chk++; n_err++;
      $display("FAIL %s: timeout, got %0d done pulses, required %0d", name, seen, n);
    end
  endtask

  task automatic wait_act(input string name);
    int cyc = 0;
    while (!mul_activate && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!mul_activate) begin
      n_chk++; n_err++;
      $display("FAIL %s: no mul_activate, got 0, required 1", name);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    int cyc;
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]       = tb_a[i];
      op_b[i*W +: W] = tb_b[i];
      op_c[i*W +: W] = tb_c[i];
    end
    @(negedge clk);
    chk("rst_mul_reset", 32'(mul_reset), 32'd1);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_activate", 32'(mul_activate), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("mul_reset_released", 32'(mul_reset), 32'd0);

    // single request
    lat = 3;
    push(0);
    req = 4'b0001;
    wait_dones(1, 1'b1, 1'b0, "single");

    // all requesting, held: 0,1,2,3,0
    do_reset();
    lat = 2;
    push(0); push(1); push(2); push(3); push(0);
    req = 4'b1111;
    wait_dones(5, 1'b0, 1'b1, "rr_all");

    // move pointer to 3, then wrap 3 -> 0
    lat = 1;
    push(2);
    req = 4'b0100;
    wait_dones(1, 1'b1, 1'b0, "ptr_to_3");
    lat = 3;
    push(3); push(0);
    req = 4'b1001;
    wait_dones(2, 1'b1, 1'b0, "wrap");

    // requester drops after grant; stray endop in ISSUE must be ignored
    lat = 5;
    glitch = 1'b1;
    push(1);
    req = 4'b0010;
    wait_act("drop_grant");
    req = '0;
    wait_dones(1, 1'b0, 1'b0, "drop_done");
    glitch = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_regrant", 32'(gnt), 32'd0);

    // reset in the middle of WAIT
    hang = 1'b1;
    gnt_q.push_back(2);
    req = 4'b0100;
    wait_act("reset_mid");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    req = '0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_mul_b", 32'(mul_b), 32'd0);
    chk("mid_rst_mul_c", 32'(mul_c), 32'd0);
    chk("mid_rst_res", 32'(res), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_mul_reset", 32'(mul_reset), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    hang = 1'b0;
    lat = 2;
    push(1);
    req = 4'b0010;
    wait_dones(1, 1'b1, 1'b0, "after_reset");

`ifdef MULT_ARB_TIMEOUT_EN
    // endop on the last allowed WAIT cycle completes normally
    lat = TMO;
    push(2);
    req = 4'b0100;
    wait_dones(1, 1'b1, 1'b0, "endop_at_limit");
    // no endop at all: abort after TMO WAIT cycles
    hang = 1'b1;
    err_exp = 1'b1;
    err_vec = 4'b1000;
    gnt_q.push_back(3);
    req = 4'b1000;
    wait_act("abort_issue");
    cyc = 0;
    while (err == '0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_latency", 32'(cyc), 32'(TMO + 1));
    req = '0;
    @(negedge clk);
    chk("abort_pulse_once", 32'(err_seen), 32'd1);
    err_exp = 1'b0;
    hang = 1'b0;
    lat = 2;
    push(0);
    req = 4'b0001;
    wait_dones(1, 1'b1, 1'b0, "after_abort");
`endif

    repeat (4) @(negedge clk);
    chk("grant_queue_drained", 32'(gnt_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
